// File: rtl/clkdiv_seq_ctrl.sv
// Purpose : accepts a {divide ratio, tick count} job and emits that many one-cycle
//           ticks spaced by the ratio, then a one-cycle done pulse.
// Latency : first tick D cycles after the accept cycle, done one cycle after the last tick.
// Backpressure: oReady is high only in IDLE (and not in reset); requests are never queued.
//
// Ports:
//   iClk, iRst            clock, synchronous active-high reset
//   ivDiv, ivNum, iValid  job request (ratio, tick count), accepted on iValid & oReady
//   oReady                idle and able to take a job (combinational)
//   iAbort                cancels a job while it is running
//   oTick, oDone, oBusy   registered tick pulse, completion pulse, job-in-progress flag
//   ovRemaining           registered count of ticks not yet emitted

module clkdiv_seq_ctrl #(
    parameter int DIV_BITS = 8,
    parameter int CNT_BITS = 8
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic [DIV_BITS-1:0] ivDiv,
    input  logic [CNT_BITS-1:0] ivNum,
    input  logic                iValid,
    output logic                oReady,
    input  logic                iAbort,
    output logic                oTick,
    output logic                oBusy,
    output logic                oDone,
    output logic [CNT_BITS-1:0] ovRemaining
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [DIV_BITS-1:0] pre_q,   pre_d;    // prescaler phase, 0..D-1
    logic [DIV_BITS-1:0] div_q,   div_d;    // latched ratio D (never 0)
    logic [CNT_BITS-1:0] rem_q,   rem_d;    // ticks not yet emitted
    logic                tick_q,  tick_d;
    logic                done_q,  done_d;
    logic                busy_q,  busy_d;

    // Ratio of the incoming request with 0 promoted to 1.
    logic [DIV_BITS-1:0] req_div;
    // Prescaler has reached D-1 and wraps this cycle.
    logic                pre_wrap;
    // Remaining count once the tick currently on oTick is accounted for.
    logic [CNT_BITS-1:0] rem_after;

    always_comb begin
        req_div   = (ivDiv == '0) ? DIV_BITS'(1) : ivDiv;
        pre_wrap  = (pre_q == (div_q - DIV_BITS'(1)));
        rem_after = tick_q ? (rem_q - CNT_BITS'(1)) : rem_q;
    end

    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        div_d   = div_q;
        rem_d   = rem_q;
        tick_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (iValid) begin
                    div_d = req_div;
                    rem_d = ivNum;
                    if (ivNum != '0) begin
                        state_d = ST_RUN;
                        // The accept cycle itself is prescaler phase 0, so the
                        // count resumes at 1 and the first tick lands D cycles
                        // after acceptance. With D=1 the phase is always 0 and the
                        // first tick is issued straight from the accept cycle.
                        if (req_div == DIV_BITS'(1)) begin
                            pre_d  = '0;
                            tick_d = 1'b1;
                        end else begin
                            pre_d  = DIV_BITS'(1);
                        end
                    end else begin
                        state_d = ST_DONE;
                        pre_d   = '0;
                        done_d  = 1'b1;
                    end
                end
            end

            ST_RUN: begin
                if (iAbort) begin
                    // The tick already on oTick (if any) is left alone; nothing new is issued.
                    state_d = ST_IDLE;
                    pre_d   = '0;
                    rem_d   = '0;
                end else begin
                    rem_d = rem_after;
                    if (tick_q && (rem_q == CNT_BITS'(1))) begin
                        // Last tick is being shown now; finish next cycle.
                        state_d = ST_DONE;
                        pre_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        pre_d  = pre_wrap ? '0 : (pre_q + DIV_BITS'(1));
                        tick_d = pre_wrap && (rem_after != '0);
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                rem_d   = '0;
            end

            default: begin
                state_d = ST_IDLE;
                pre_d   = '0;
                rem_d   = '0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= ST_IDLE;
            pre_q   <= '0;
            div_q   <= DIV_BITS'(1);
            rem_q   <= '0;
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            div_q   <= div_d;
            rem_q   <= rem_d;
            tick_q  <= tick_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    // Ready is masked by reset directly so it drops in the reset cycle itself.
    assign oReady      = (state_q == ST_IDLE) && !iRst;
    assign oTick       = tick_q;
    assign oDone       = done_q;
    assign oBusy       = busy_q;
    assign ovRemaining = rem_q;

endmodule

// File: tb/tb_clkdiv_seq_ctrl.sv
module tb_clkdiv_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid;
    logic       abort;
    logic [7:0] div;
    logic [7:0] num;
    logic       ready;
    logic       tick;
    logic       busy;
    logic       done;
    logic [7:0] rem;

    always #5 clk = ~clk;

    clkdiv_seq_ctrl #(.DIV_BITS(8), .CNT_BITS(8)) dut (
        .iClk        (clk),
        .iRst        (rst),
        .ivDiv       (div),
        .ivNum       (num),
        .iValid      (valid),
        .oReady      (ready),
        .iAbort      (abort),
        .oTick       (tick),
        .oBusy       (busy),
        .oDone       (done),
        .ovRemaining (rem)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A job is described by its accept cycle c0, ratio D and count N. Everything
    // else follows arithmetically from the cycle offset k = t - c0.
    int cyc   = 0;   // index of the current cycle (number of rising edges seen)
    bit m_act = 0;
    int m_c0  = 0;
    int m_d   = 1;
    int m_n   = 0;

    function int m_last();
        return (m_n == 0) ? 1 : (m_n * m_d + 1);
    endfunction

    function bit m_live(input int t);
        int k;
        k = t - m_c0;
        return m_act && (k >= 1) && (k <= m_last());
    endfunction

    function bit m_running(input int t);
        int k;
        k = t - m_c0;
        return m_live(t) && (m_n > 0) && (k <= m_n * m_d);
    endfunction

    always @(posedge clk) begin
        int cur;
        cur = cyc;
        if (rst === 1'b1) begin
            m_act = 0;
        end else if (!m_live(cur)) begin
            if (valid === 1'b1) begin
                m_act = 1;
                m_c0  = cur;
                m_d   = (div == 8'd0) ? 1 : int'(div);
                m_n   = int'(num);
            end
        end else if (abort === 1'b1 && m_running(cur)) begin
            m_act = 0;
        end
        cyc = cur + 1;
    end

    bit chk_en = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            int  t, k;
            bit  live, run, e_tick, e_done, e_ready;
            int  e_rem;
            t       = cyc;
            k       = t - m_c0;
            live    = m_live(t);
            run     = m_running(t);
            e_tick  = run && ((k % m_d) == 0);
            e_done  = live && (k == m_last());
            e_rem   = run ? (m_n - (k - 1) / m_d) : 0;
            e_ready = !live && (rst !== 1'b1);
            chk($sformatf("cyc%0d oTick", t),       64'(tick),  64'(e_tick));
            chk($sformatf("cyc%0d oDone", t),       64'(done),  64'(e_done));
            chk($sformatf("cyc%0d oBusy", t),       64'(busy),  64'(live));
            chk($sformatf("cyc%0d oReady", t),      64'(ready), 64'(e_ready));
            chk($sformatf("cyc%0d ovRemaining", t), 64'(rem),   64'(e_rem));
        end
    end

    // ---------------- capture for literal expectations ----------------
    bit          cap_en = 0;
    int          base   = 0;
    logic [63:0] tick_mask;
    logic [63:0] done_mask;
    int          first_ready;
    int          busy_cnt;
    int          rem_at [64];

    always @(negedge clk) begin
        if (cap_en) begin
            int k;
            k = cyc - base;
            if (k >= 0 && k < 64) begin
                if (tick === 1'b1) tick_mask[k] = 1'b1;
                if (done === 1'b1) done_mask[k] = 1'b1;
                if (ready === 1'b1 && k >= 1 && first_ready < 0) first_ready = k;
                if (busy === 1'b1) busy_cnt++;
                rem_at[k] = int'(rem);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_cap();
        tick_mask   = '0;
        done_mask   = '0;
        first_ready = -1;
        busy_cnt    = 0;
        for (int i = 0; i < 64; i++) rem_at[i] = -1;
        base   = cyc;
        cap_en = 1;
    endtask

    task automatic submit(input logic [7:0] d, input logic [7:0] n);
        int w;
        w = 0;
        while (ready !== 1'b1 && w < 300) begin
            step(1);
            w++;
        end
        if (w >= 300) chk("ready_timeout", 64'd0, 64'd1);
        start_cap();
        valid = 1'b1;
        div   = d;
        num   = n;
        step(1);
        valid = 1'b0;
    endtask

    function logic [63:0] bit_at(input int i);
        logic [63:0] one;
        one = 64'd1;
        return one << i;
    endfunction

    initial begin
        rst   = 1'b1;
        valid = 1'b0;
        abort = 1'b0;
        div   = 8'd0;
        num   = 8'd0;
        step(1);
        chk_en = 1;
        chk("reset oReady", 64'(ready), 64'd0);
        chk("reset oBusy",  64'(busy),  64'd0);
        chk("reset ovRemaining", 64'(rem), 64'd0);
        step(2);
        rst = 1'b0;
        step(1);
        chk("post-reset oReady", 64'(ready), 64'd1);

        // D=3, N=2
        submit(8'd3, 8'd2);
        step(10);
        chk("d3n2 ticks",   tick_mask, bit_at(3) | bit_at(6));
        chk("d3n2 done",    done_mask, bit_at(7));
        chk("d3n2 ready",   64'(first_ready), 64'd8);
        chk("d3n2 busy",    64'(busy_cnt), 64'd7);
        chk("d3n2 rem@1",   64'(rem_at[1]), 64'd2);
        chk("d3n2 rem@4",   64'(rem_at[4]), 64'd1);
        chk("d3n2 rem@7",   64'(rem_at[7]), 64'd0);

        // D=0 treated as 1, N=3
        submit(8'd0, 8'd3);
        step(6);
        chk("d0n3 ticks", tick_mask, bit_at(1) | bit_at(2) | bit_at(3));
        chk("d0n3 done",  done_mask, bit_at(4));

        // N=0
        submit(8'd5, 8'd0);
        step(4);
        chk("n0 ticks", tick_mask, 64'd0);
        chk("n0 done",  done_mask, bit_at(1));
        chk("n0 busy",  64'(busy_cnt), 64'd1);
        chk("n0 ready", 64'(first_ready), 64'd2);

        // Abort at c0+9 of D=4, N=5
        submit(8'd4, 8'd5);
        step(8);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        step(12);
        chk("abort ticks",  tick_mask, bit_at(4) | bit_at(8));
        chk("abort done",   done_mask, 64'd0);
        chk("abort ready",  64'(first_ready), 64'd10);
        chk("abort rem@10", 64'(rem_at[10]), 64'd0);

        // Request held during a running job; picked up at the first ready cycle
        submit(8'd2, 8'd3);
        valid = 1'b1;
        div   = 8'd7;
        num   = 8'd1;
        step(8);
        valid = 1'b0;
        step(12);
        chk("hold ticks", tick_mask, bit_at(2) | bit_at(4) | bit_at(6) | bit_at(15));
        chk("hold done",  done_mask, bit_at(7) | bit_at(16));
        chk("hold ready", 64'(first_ready), 64'd8);

        // Reset in the middle of D=2, N=10
        submit(8'd2, 8'd10);
        step(4);
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(3);
        chk("mrst ticks", tick_mask, bit_at(2) | bit_at(4));
        chk("mrst done",  done_mask, 64'd0);
        chk("mrst ready", 64'(first_ready), 64'd7);
        chk("mrst busy",  64'(busy_cnt), 64'd5);

        // Recovery: D=1, N=1
        submit(8'd1, 8'd1);
        step(4);
        chk("recover ticks", tick_mask, bit_at(1));
        chk("recover done",  done_mask, bit_at(2));

        cap_en = 0;
        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
